// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku propagation controller.
package sudoku_pkg;

  localparam int unsigned N      = 9;
  localparam int unsigned NCELL  = 81;
  localparam int unsigned MASK_W = 729;

  typedef enum logic [1:0] {
    ST_SOLVED  = 2'd0,
    ST_STUCK   = 2'd1,
    ST_INVALID = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    ISSUE = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Bit position of "digit d excluded at cell (x,y)".
  function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                      input int unsigned d);
    return x * 81 + y * 9 + d;
  endfunction

endpackage

// File: rtl/sudoku_cell_status.sv
// Per-cell exclusion popcount of a full mask, reduced to any-dead / all-fixed flags.
module sudoku_cell_status
  import sudoku_pkg::*;
(
  input  logic [MASK_W-1:0] mask_i,
  output logic              any_dead_o,
  output logic              all_fixed_o
);

  logic [NCELL-1:0] dead;
  logic [NCELL-1:0] fixed;

  for (genvar c = 0; c < NCELL; c++) begin : g_cell
    localparam int unsigned Base = idx(c / N, c % N, 0);
    logic [N-1:0] bits;
    logic [3:0]   cnt;

    assign bits = mask_i[Base +: N];

    always_comb begin
      cnt = '0;
      for (int d = 0; d < N; d++) begin
        cnt = cnt + 4'(bits[d]);
      end
    end

    assign dead[c]  = (cnt == 4'd9);
    assign fixed[c] = (cnt == 4'd8);
  end

  assign any_dead_o  = |dead;
  assign all_fixed_o = &fixed;

endmodule

// File: rtl/sudoku_prop_ctrl.sv
// Iterates a candidate-exclusion mask through the external stg2 stage until a verdict.
// Define SUDOKU_PROP_PIPE_EN to register prop_mask_i and split each pass into ISSUE/EVAL.
module sudoku_prop_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned MAX_ITER = 32,
  parameter int unsigned ITER_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [MASK_W-1:0] mask_in,
  output logic [MASK_W-1:0] prop_mask_o,
  input  logic [MASK_W-1:0] prop_mask_i,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [MASK_W-1:0] mask_out,
  output logic [ITER_W-1:0] iter_count
);

  state_e              state_q;
  logic [MASK_W-1:0]   mask_q;
  logic [ITER_W-1:0]   iter_q;
  logic                busy_q;
  logic                done_q;
  status_e             status_q;
  logic [MASK_W-1:0]   mask_out_q;
  logic [ITER_W-1:0]   iter_out_q;

  logic                any_dead;
  logic                all_fixed;
  logic [MASK_W-1:0]   eval_mask;
  status_e             verdict;
  logic                verdict_vld;

`ifdef SUDOKU_PROP_PIPE_EN
  localparam state_e PassSt = ISSUE;
  logic [MASK_W-1:0] prop_q;
  assign eval_mask = prop_q;
`else
  localparam state_e PassSt = RUN;
  assign eval_mask = prop_mask_i;
`endif

  sudoku_cell_status u_cell_status (
    .mask_i      (mask_q),
    .any_dead_o  (any_dead),
    .all_fixed_o (all_fixed)
  );

  always_comb begin
    verdict     = ST_TIMEOUT;
    verdict_vld = 1'b1;
    if (any_dead) begin
      verdict = ST_INVALID;
    end else if (eval_mask == mask_q) begin
      verdict = all_fixed ? ST_SOLVED : ST_STUCK;
    end else if (iter_q == ITER_W'(MAX_ITER)) begin
      verdict = ST_TIMEOUT;
    end else begin
      verdict_vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= ST_SOLVED;
      mask_out_q <= '0;
      iter_out_q <= '0;
`ifdef SUDOKU_PROP_PIPE_EN
      prop_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            mask_q  <= mask_in;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= PassSt;
          end
        end
`ifdef SUDOKU_PROP_PIPE_EN
        ISSUE: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            prop_q  <= prop_mask_i;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (verdict_vld) begin
            status_q   <= verdict;
            mask_out_q <= mask_q;
            iter_out_q <= iter_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            mask_q  <= prop_q;
            iter_q  <= iter_q + ITER_W'(1);
            state_q <= ISSUE;
          end
        end
`else
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (verdict_vld) begin
            status_q   <= verdict;
            mask_out_q <= mask_q;
            iter_out_q <= iter_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            // Counter only advances below MAX_ITER, so it saturates rather than wraps.
            mask_q <= prop_mask_i;
            iter_q <= iter_q + ITER_W'(1);
          end
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prop_mask_o = mask_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign mask_out    = mask_out_q;
  assign iter_count  = iter_out_q;

endmodule

// File: tb/tb_sudoku_prop_ctrl.sv
// Bench for sudoku_prop_ctrl: elimination-stage model and a one-bit-per-pass stub drive two DUTs.
module tb_sudoku_prop_ctrl;
  import sudoku_pkg::*;

  localparam int MAXA = 32;
  localparam int MAXB = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic         abort = 1'b0;
  logic [728:0] mask_in = '0;
  logic [728:0] po_a, pi_a, po_b, pi_b, mo_a, mo_b;
  logic         busy_a, done_a, busy_b, done_b;
  logic [1:0]   st_a, st_b;
  logic [7:0]   it_a, it_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sudoku_prop_ctrl #(.MAX_ITER(MAXA), .ITER_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .mask_in(mask_in),
    .prop_mask_o(po_a), .prop_mask_i(pi_a), .busy(busy_a), .done(done_a),
    .status(st_a), .mask_out(mo_a), .iter_count(it_a)
  );

  sudoku_prop_ctrl #(.MAX_ITER(MAXB), .ITER_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .mask_in(mask_in),
    .prop_mask_o(po_b), .prop_mask_i(pi_b), .busy(busy_b), .done(done_b),
    .status(st_b), .mask_out(mo_b), .iter_count(it_b)
  );

  function automatic int sol(input int c);
    int x, y;
    x = c / 9;
    y = c % 9;
    return (3 * (x % 3) + x / 3 + y) % 9;
  endfunction

  function automatic int cnt(input logic [728:0] m, input int c);
    int s;
    s = 0;
    for (int d = 0; d < 9; d++) s += int'(m[c*9+d]);
    return s;
  endfunction

  function automatic bit peer(input int a, input int b);
    if (a == b) return 1'b0;
    if (a / 9 == b / 9 || a % 9 == b % 9) return 1'b1;
    return ((a / 9) / 3 == (b / 9) / 3) && ((a % 9) / 3 == (b % 9) / 3);
  endfunction

  // One naked-single elimination pass: a solved cell excludes its digit from all peers.
  function automatic logic [728:0] elim(input logic [728:0] m);
    logic [728:0] r;
    int v;
    r = m;
    for (int c = 0; c < 81; c++) begin
      v = -1;
      if (cnt(m, c) == 8) begin
        for (int d = 0; d < 9; d++) if (!m[c*9+d]) v = d;
      end
      if (v >= 0) begin
        for (int p = 0; p < 81; p++) if (peer(c, p)) r[p*9+v] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [728:0] add_bit(input logic [728:0] m);
    logic [728:0] r;
    r = m;
    for (int i = 0; i < 729; i++) begin
      if (!m[i]) begin
        r[i] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  always_comb pi_a = elim(po_a);
  always_comb pi_b = add_bit(po_b);

  function automatic bit any_dead_f(input logic [728:0] m);
    for (int c = 0; c < 81; c++) if (cnt(m, c) == 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit all_fixed_f(input logic [728:0] m);
    for (int c = 0; c < 81; c++) if (cnt(m, c) != 8) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input logic [728:0] m0, input bit stub, input int maxit,
                       output logic [1:0] st, output int n, output logic [728:0] mo);
    logic [728:0] m, p;
    m = m0;
    n = 0;
    st = 2'd0;
    while (1) begin
      p = stub ? add_bit(m) : elim(m);
      if (any_dead_f(m)) begin st = 2'd2; break; end
      if (p == m) begin st = all_fixed_f(m) ? 2'd0 : 2'd1; break; end
      if (n == maxit) begin st = 2'd3; break; end
      m = p;
      n++;
    end
    mo = m;
  endtask

  function automatic logic [728:0] gen_open(input int nopen);
    logic [728:0] m;
    int c;
    m = '1;
    for (int k = 0; k < 81; k++) m[k*9+sol(k)] = 1'b0;
    for (int k = 0; k < nopen; k++) begin
      c = $urandom_range(0, 80);
      for (int d = 0; d < 9; d++) m[c*9+d] = 1'b0;
    end
    return m;
  endfunction

  function automatic int exp_lat(input int n);
`ifdef SUDOKU_PROP_PIPE_EN
    return 2 * n + 3;
`else
    return n + 2;
`endif
  endfunction

  task automatic chk(input string tag, input logic [728:0] obs, input logic [728:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit sel, input logic [728:0] m, input bit dbl, input string tag);
    logic [1:0]   est;
    int           en, cyc, extra;
    logic [728:0] emo;
    model(m, sel, sel ? MAXB : MAXA, est, en, emo);
    @(posedge clk); #1;
    mask_in = m;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = 1;
    chk({tag, ".busy"}, sel ? busy_b : busy_a, 1'b1);
    if (dbl) begin
      mask_in = '0;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end
    while (!(sel ? done_b : done_a) && cyc < 300) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
    end
    chk({tag, ".lat"}, cyc, exp_lat(en));
    chk({tag, ".status"}, sel ? st_b : st_a, est);
    chk({tag, ".iter"}, sel ? it_b : it_a, en);
    chk({tag, ".mask_out"}, sel ? mo_b : mo_a, emo);
    @(posedge clk); #1;
    chk({tag, ".done_clr"}, sel ? done_b : done_a, 1'b0);
    chk({tag, ".held"}, sel ? st_b : st_a, est);
    if (dbl) begin
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (sel ? done_b : done_a) extra++;
      end
      chk({tag, ".no_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    logic [728:0] m, best;
    logic [1:0]   st;
    int           n, best_n, kind, c, extra;
    logic [728:0] mo;

    #1;
    chk("rst.busy", busy_a, 1'b0);
    chk("rst.done", done_a, 1'b0);
    chk("rst.status", st_a, 2'd0);
    chk("rst.mask_out", mo_a, '0);
    chk("rst.iter", it_a, 0);
    chk("rst.prop_mask_o", po_b, '0);
    #13 rst_n = 1'b1;

    run(1'b0, gen_open(0), 1'b0, "solved");
    m = '0;
    m[8:0] = '1;
    run(1'b0, m, 1'b0, "dead");
    run(1'b0, '0, 1'b0, "stuck");
    run(1'b1, '0, 1'b0, "timeout");

    // Look for a puzzle needing several elimination passes, ideally four.
    best = gen_open(0);
    best_n = -1;
    for (int t = 0; t < 400 && best_n != 4; t++) begin
      m = gen_open($urandom_range(30, 58));
      model(m, 1'b0, MAXA, st, n, mo);
      if (st == 2'd0 && n > best_n && n <= 4) begin
        best_n = n;
        best = m;
      end
    end
    run(1'b0, best, 1'b1, "multipass");

    // Abort on dut_b during its second RUN cycle; previous TIMEOUT result must persist.
    @(posedge clk); #1;
    mask_in = '0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.busy", busy_b, 1'b0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_b) extra++;
    end
    chk("abort.no_done", extra, 0);
    chk("abort.status_held", st_b, 2'd3);
    chk("abort.iter_held", it_b, 3);

    for (int r = 0; r < 12; r++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: m = gen_open($urandom_range(0, 60));
        1: begin
          m = gen_open($urandom_range(0, 40));
          c = $urandom_range(0, 80);
          for (int d = 0; d < 9; d++) m[c*9+d] = 1'b1;
          m[c*9+(sol(c)+1)%9] = 1'b0;
        end
        2: for (int i = 0; i < 729; i++) m[i] = ($urandom_range(0, 3) == 0);
        default: begin
          m = gen_open($urandom_range(10, 60));
          c = $urandom_range(0, 80);
          for (int d = 0; d < 9; d++) m[c*9+d] = 1'b1;
        end
      endcase
      run(1'b0, m, 1'b0, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1;
    mask_in = '0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", busy_b, 1'b0);
    chk("mrst.done", done_b, 1'b0);
    chk("mrst.status", st_b, 2'd0);
    chk("mrst.iter", it_b, 0);
    chk("mrst.mask_out", mo_b, '0);
    chk("mrst.prop_mask_o", po_b, '0);
    #2 rst_n = 1'b1;
    run(1'b1, '0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
